// File: rtl/mem_pkg.sv
// Shared types for the unified memory arbiter: FSM states, port owner, latency bound.
// No logic; types and constants only.
// No flow control of its own.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic {
    OWN_FETCH,
    OWN_DATA
  } owner_t;

  localparam int MAX_LATENCY = 4;

endpackage

// File: rtl/unified_mem_arb_if.sv
// Fetch and load/store request/response bundle between the pipeline and the arbiter.
// No logic; wires only.
// Requests wait for gnt; responses are single-cycle valid pulses with no back-pressure.
interface unified_mem_arb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_valid;
  logic [DATA_W-1:0]     if_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [DATA_W/8-1:0]   d_mask;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic                  d_gnt;
  logic                  d_valid;
  logic [DATA_W-1:0]     d_rdata;

  logic                  busy;

  modport master (
    output if_req, if_addr, d_req, d_we, d_mask, d_addr, d_wdata,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata, busy
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_mask, d_addr, d_wdata,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata, busy
  );
endinterface

// File: rtl/mem_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Latency: read data appears the cycle after an enabled read; writes land on the enable edge.
// No back-pressure; out-of-range writes are dropped and out-of-range reads return zero.
module mem_array #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);
  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              in_range;

  assign idx      = addr[IDX_W-1:0];
  assign in_range = {1'b0, addr} < DEPTH_L;

  // One access per enable: byte-masked write, or registered read (zero when out of range).
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        if (in_range) begin
          for (int b = 0; b < NB; b++) begin
            if (be[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
          end
        end
      end else begin
        rdata <= in_range ? mem[idx] : '0;
      end
    end
  end
endmodule

// File: rtl/unified_mem_arb.sv
// Shares one single-port RAM between fetch and load/store through a round-robin-on-conflict arbiter.
// Latency: gnt in cycle T, valid pulse in cycle T+LATENCY; next grant no earlier than T+LATENCY+1.
// Back-pressure: requests are held until gnt; gnt only while IDLE, so one access is in flight at a time.
module unified_mem_arb
  import mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  unified_mem_arb_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_LATENCY + 1);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(LATENCY - 1);

  state_t            state;
  owner_t            owner;
  owner_t            last_winner;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic              if_valid_q;
  logic              d_valid_q;
  logic              busy_q;
  logic [DATA_W-1:0] if_hold;
  logic [DATA_W-1:0] d_hold;
  logic [DATA_W-1:0] ram_q;
  logic              if_gnt_c;
  logic              d_gnt_c;
  logic              acc;

  // Grant only in IDLE; on conflict the loser of the previous conflict goes first.
  always_comb begin
    if_gnt_c = 1'b0;
    d_gnt_c  = 1'b0;
    if (rst && state == IDLE) begin
      if (bus.if_req && bus.d_req) begin
        if (last_winner == OWN_DATA) if_gnt_c = 1'b1;
        else                         d_gnt_c  = 1'b1;
      end else begin
        if_gnt_c = bus.if_req;
        d_gnt_c  = bus.d_req;
      end
    end
  end

  assign acc = if_gnt_c | d_gnt_c;

  // The RAM is touched only at the grant edge, so later requests always see earlier writes
  // and the read word stays parked in ram_q until the response cycle.
  mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .en    (acc),
    .we    (d_gnt_c & bus.d_we),
    .be    (bus.d_mask),
    .addr  (d_gnt_c ? bus.d_addr : bus.if_addr),
    .wdata (bus.d_wdata),
    .rdata (ram_q)
  );

  // Access FSM: records the owner at grant, counts wait states, pulses the owner's valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      owner       <= OWN_FETCH;
      last_winner <= OWN_FETCH;
      cnt         <= '0;
      we_q        <= 1'b0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      if_hold     <= '0;
      d_hold      <= '0;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (acc) begin
            owner  <= d_gnt_c ? OWN_DATA : OWN_FETCH;
            we_q   <= d_gnt_c & bus.d_we;
            busy_q <= 1'b1;
            if (bus.if_req && bus.d_req) last_winner <= d_gnt_c ? OWN_DATA : OWN_FETCH;
            if (LATENCY == 1) begin
              state      <= RESP;
              if_valid_q <= if_gnt_c;
              d_valid_q  <= d_gnt_c;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == CNT_W'(1)) begin
            state      <= RESP;
            if_valid_q <= (owner == OWN_FETCH);
            d_valid_q  <= (owner == OWN_DATA);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          if (!we_q) begin
            if (owner == OWN_FETCH) if_hold <= ram_q;
            else                    d_hold  <= ram_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read responses show the RAM word live; otherwise each port keeps its last read word.
  assign bus.if_rdata = (if_valid_q && !we_q) ? ram_q : if_hold;
  assign bus.d_rdata  = (d_valid_q  && !we_q) ? ram_q : d_hold;
  assign bus.if_gnt   = if_gnt_c;
  assign bus.d_gnt    = d_gnt_c;
  assign bus.if_valid = if_valid_q;
  assign bus.d_valid  = d_valid_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_unified_mem_arb.sv
// Directed bench for unified_mem_arb: three instances (LATENCY 1/DEPTH 256, LATENCY 3/DEPTH 128, LATENCY 4/DEPTH 256).
// A vector table drives single transactions; hand sequences cover contention, ordering and reset mid-access.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_unified_mem_arb;
  localparam int N = 3;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic        rst_n    [N];
  logic        if_req   [N];
  logic [7:0]  if_addr  [N];
  logic        d_req    [N];
  logic        d_we     [N];
  logic [3:0]  d_mask   [N];
  logic [7:0]  d_addr   [N];
  logic [31:0] d_wdata  [N];
  logic        if_gnt_o [N];
  logic        if_vld_o [N];
  logic [31:0] if_rd_o  [N];
  logic        d_gnt_o  [N];
  logic        d_vld_o  [N];
  logic [31:0] d_rd_o   [N];
  logic        busy_o   [N];

  always #5 clk = ~clk;

  // Free-running cycle index used to measure grant and response timing.
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    localparam int DEP = (g == 1) ? 128 : 256;
    unified_mem_arb_if #(.DATA_W(32), .ADDR_W(8)) bus ();
    assign bus.if_req  = if_req[g];
    assign bus.if_addr = if_addr[g];
    assign bus.d_req   = d_req[g];
    assign bus.d_we    = d_we[g];
    assign bus.d_mask  = d_mask[g];
    assign bus.d_addr  = d_addr[g];
    assign bus.d_wdata = d_wdata[g];
    assign if_gnt_o[g] = bus.if_gnt;
    assign if_vld_o[g] = bus.if_valid;
    assign if_rd_o[g]  = bus.if_rdata;
    assign d_gnt_o[g]  = bus.d_gnt;
    assign d_vld_o[g]  = bus.d_valid;
    assign d_rd_o[g]   = bus.d_rdata;
    assign busy_o[g]   = bus.busy;
    unified_mem_arb #(.DATA_W(32), .ADDR_W(8), .DEPTH(DEP), .LATENCY(LAT)) dut (
      .clk (clk),
      .rst (rst_n[g]),
      .bus (bus)
    );
  end

  typedef struct {
    int          k;
    bit          port;   // 0 = fetch, 1 = data
    bit          we;
    logic [7:0]  addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] exp;    // expected read data (reads only)
  } vec_t;

  vec_t        vecs [20];
  logic [31:0] last_rd [N][2];

  function automatic vec_t mk(int k, bit port, bit we, logic [7:0] addr, logic [3:0] mask,
                              logic [31:0] wdata, logic [31:0] exp);
    vec_t v;
    v.k = k; v.port = port; v.we = we; v.addr = addr; v.mask = mask; v.wdata = wdata; v.exp = exp;
    return v;
  endfunction

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 4;
  endfunction

  function automatic logic gnt_of(int k, bit p);
    return p ? d_gnt_o[k] : if_gnt_o[k];
  endfunction

  function automatic logic vld_of(int k, bit p);
    return p ? d_vld_o[k] : if_vld_o[k];
  endfunction

  function automatic logic [31:0] rd_of(int k, bit p);
    return p ? d_rd_o[k] : if_rd_o[k];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v, input logic on);
    if (v.port) begin
      d_req[v.k]   = on;
      d_we[v.k]    = v.we;
      d_addr[v.k]  = v.addr;
      d_mask[v.k]  = v.mask;
      d_wdata[v.k] = v.wdata;
    end else begin
      if_req[v.k]  = on;
      if_addr[v.k] = v.addr;
    end
  endtask

  task automatic reset_dut(input int k);
    rst_n[k] = 1'b0;
    @(posedge clk); #1;
    rst_n[k] = 1'b1;
    last_rd[k][0] = '0;
    last_rd[k][1] = '0;
    @(posedge clk); #1;
  endtask

  // One isolated transaction: grant must be immediate, valid exactly LATENCY later, one cycle wide.
  task automatic xact(input vec_t v, input string tag);
    int t_d, t_g, t_v;
    bit got;
    logic [31:0] expd;
    t_g = 0; t_v = 0;
    drive_req(v, 1'b1);
    t_d = cyc;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt_of(v.k, v.port)) begin got = 1; t_g = cyc; break; end
    end
    chk({tag, " gnt_delay"}, got ? 32'(t_g - t_d) : 32'hFFFF_FFFF, 32'd0);
    @(posedge clk); #1;
    drive_req(v, 1'b0);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (vld_of(v.k, v.port)) begin got = 1; t_v = cyc; break; end
    end
    chk({tag, " latency"}, got ? 32'(t_v - t_g) : 32'hFFFF_FFFF, 32'(lat_of(v.k)));
    expd = v.we ? last_rd[v.k][v.port] : v.exp;
    chk({tag, " rdata"}, rd_of(v.k, v.port), expd);
    if (!v.we) last_rd[v.k][v.port] = v.exp;
    @(negedge clk);
    chk({tag, " valid_width"}, 32'(vld_of(v.k, v.port)), 32'd0);
    chk({tag, " busy_after"}, 32'(busy_o[v.k]), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d, expected completion", cyc);
    $fatal(1);
  end

  initial begin
    int pulses;
    for (int k = 0; k < N; k++) begin
      rst_n[k] = 1'b0; if_req[k] = 1'b0; if_addr[k] = '0; d_req[k] = 1'b0; d_we[k] = 1'b0;
      d_mask[k] = '0; d_addr[k] = '0; d_wdata[k] = '0; last_rd[k][0] = '0; last_rd[k][1] = '0;
    end

    vecs[0]  = mk(0, 1, 1, 8'd5,   4'hF, 32'hDEADBEEF, 32'h0);
    vecs[1]  = mk(0, 0, 0, 8'd5,   4'h0, 32'h0,        32'hDEADBEEF);
    vecs[2]  = mk(0, 1, 0, 8'd5,   4'h0, 32'h0,        32'hDEADBEEF);
    vecs[3]  = mk(0, 1, 1, 8'd255, 4'hF, 32'h0BADF00D, 32'h0);
    vecs[4]  = mk(0, 1, 0, 8'd255, 4'h0, 32'h0,        32'h0BADF00D);
    vecs[5]  = mk(0, 1, 1, 8'd5,   4'h0, 32'hFFFFFFFF, 32'h0);
    vecs[6]  = mk(0, 0, 0, 8'd5,   4'h0, 32'h0,        32'hDEADBEEF);
    vecs[7]  = mk(1, 1, 1, 8'd2,   4'hF, 32'h11223344, 32'h0);
    vecs[8]  = mk(1, 1, 1, 8'd2,   4'h5, 32'hAABBCCDD, 32'h0);
    vecs[9]  = mk(1, 1, 0, 8'd2,   4'h0, 32'h0,        32'h11BB33DD);
    vecs[10] = mk(1, 1, 1, 8'd127, 4'hF, 32'hCAFEF00D, 32'h0);
    vecs[11] = mk(1, 1, 1, 8'd72,  4'hF, 32'h72727272, 32'h0);
    vecs[12] = mk(1, 1, 0, 8'd200, 4'h0, 32'h0,        32'h00000000);
    vecs[13] = mk(1, 1, 1, 8'd200, 4'hF, 32'hFFFFFFFF, 32'h0);
    vecs[14] = mk(1, 1, 0, 8'd127, 4'h0, 32'h0,        32'hCAFEF00D);
    vecs[15] = mk(1, 0, 0, 8'd72,  4'h0, 32'h0,        32'h72727272);
    vecs[16] = mk(1, 1, 0, 8'd2,   4'h0, 32'h0,        32'h11BB33DD);
    vecs[17] = mk(1, 0, 0, 8'd128, 4'h0, 32'h0,        32'h00000000);
    vecs[18] = mk(2, 1, 1, 8'd9,   4'hF, 32'h00000099, 32'h0);
    vecs[19] = mk(2, 0, 0, 8'd9,   4'h0, 32'h0,        32'h00000099);

    // Reset state of every instance.
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rst%0d if_gnt", k),   32'(if_gnt_o[k]), 32'd0);
      chk($sformatf("rst%0d d_gnt", k),    32'(d_gnt_o[k]),  32'd0);
      chk($sformatf("rst%0d if_valid", k), 32'(if_vld_o[k]), 32'd0);
      chk($sformatf("rst%0d d_valid", k),  32'(d_vld_o[k]),  32'd0);
      chk($sformatf("rst%0d busy", k),     32'(busy_o[k]),   32'd0);
      chk($sformatf("rst%0d if_rdata", k), if_rd_o[k],       32'd0);
      chk($sformatf("rst%0d d_rdata", k),  d_rd_o[k],        32'd0);
    end
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) rst_n[k] = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) xact(vecs[i], $sformatf("v%0d", i));

    // Simultaneous data write and fetch of the same word: data wins first conflict, fetch sees new data.
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 8'd7; d_mask[0] = 4'hF; d_wdata[0] = 32'h00000013;
    if_req[0] = 1'b1; if_addr[0] = 8'd7;
    @(negedge clk);
    chk("raw d_gnt_first", 32'(d_gnt_o[0]), 32'd1);
    chk("raw if_gnt_first", 32'(if_gnt_o[0]), 32'd0);
    @(posedge clk); #1;
    d_req[0] = 1'b0;
    @(negedge clk);
    chk("raw d_ack", 32'(d_vld_o[0]), 32'd1);
    chk("raw no_gnt_in_resp", 32'(if_gnt_o[0]), 32'd0);
    @(negedge clk);
    chk("raw if_gnt_second", 32'(if_gnt_o[0]), 32'd1);
    @(posedge clk); #1;
    if_req[0] = 1'b0;
    @(negedge clk);
    chk("raw if_valid", 32'(if_vld_o[0]), 32'd1);
    chk("raw if_rdata", if_rd_o[0], 32'h00000013);
    @(posedge clk); #1;

    // Contention fairness from reset: both held, grants alternate DATA, FETCH every two cycles.
    reset_dut(0);
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 8'd5;
    if_req[0] = 1'b1; if_addr[0] = 8'd5;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("rr c%0d d_gnt", c),    32'(d_gnt_o[0]),  32'(c % 4 == 0));
      chk($sformatf("rr c%0d if_gnt", c),   32'(if_gnt_o[0]), 32'(c % 4 == 2));
      chk($sformatf("rr c%0d d_valid", c),  32'(d_vld_o[0]),  32'(c % 4 == 1));
      chk($sformatf("rr c%0d if_valid", c), 32'(if_vld_o[0]), 32'(c % 4 == 3));
      if (c % 4 == 1) chk($sformatf("rr c%0d d_rdata", c), d_rd_o[0], 32'hDEADBEEF);
      if (c % 4 == 3) chk($sformatf("rr c%0d if_rdata", c), if_rd_o[0], 32'hDEADBEEF);
      @(posedge clk); #1;
    end
    d_req[0] = 1'b0; if_req[0] = 1'b0;
    @(posedge clk); #1;

    // Reset two cycles into a LATENCY=4 write: no response, outputs cleared, write stays committed.
    d_req[2] = 1'b1; d_we[2] = 1'b1; d_addr[2] = 8'd10; d_mask[2] = 4'hF; d_wdata[2] = 32'h00000055;
    @(negedge clk);
    chk("rma d_gnt", 32'(d_gnt_o[2]), 32'd1);
    @(posedge clk); #1;
    d_req[2] = 1'b0;
    pulses = 0;
    @(negedge clk);
    if (d_vld_o[2]) pulses++;
    @(posedge clk); #1;
    rst_n[2] = 1'b0;
    @(negedge clk);
    chk("rma busy", 32'(busy_o[2]), 32'd0);
    chk("rma d_valid", 32'(d_vld_o[2]), 32'd0);
    chk("rma if_rdata", if_rd_o[2], 32'd0);
    chk("rma d_rdata", d_rd_o[2], 32'd0);
    @(posedge clk); #1;
    rst_n[2] = 1'b1;
    last_rd[2][0] = '0; last_rd[2][1] = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (d_vld_o[2]) pulses++;
    end
    chk("rma no_valid_pulse", 32'(pulses), 32'd0);
    chk("rma idle_busy", 32'(busy_o[2]), 32'd0);
    @(posedge clk); #1;
    xact(mk(2, 1, 0, 8'd10, 4'h0, 32'h0, 32'h00000055), "rma read10");
    xact(mk(2, 0, 0, 8'd9,  4'h0, 32'h0, 32'h00000099), "rma read9");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/unified_mem_arb.md
Name: unified_mem_arb

Overview:
- Parametrised successor to the per-port request-driven memory. Holds one single-port word-addressed RAM with byte-masked writes and a configurable number of read/write wait states.
- Shares the RAM between the fetch port and the load/store port through a two-requestor arbiter with a req/gnt/valid handshake.
- Sits between fetch/memory stages and storage, so the datapath can stall on multi-cycle memory instead of assuming single-cycle access.

Parameters:
- DATA_W, 32, data word width; must be a multiple of 8.
- ADDR_W, 8, word-address width on both ports.
- DEPTH, 256, number of words; DEPTH <= 2**ADDR_W.
- LATENCY, 1, cycles from grant to response; legal range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset (0 = reset).
- if_req  in  1  fetch read request.
- if_addr  in  ADDR_W  fetch word address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_valid  out  1  fetch response pulse.
- if_rdata  out  DATA_W  fetch read data.
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read.
- d_mask  in  DATA_W/8  byte enables for writes.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  write data.
- d_gnt  out  1  data request accepted this cycle.
- d_valid  out  1  data response pulse (read data or write ack).
- d_rdata  out  DATA_W  data read data.
- busy  out  1  access in flight.

Behaviour:
- Reset (async, rst=0):
  - FSM to IDLE; counter 0; if_gnt, d_gnt, if_valid, d_valid and busy all 0.
  - if_rdata and d_rdata cleared to 0; last_winner set to FETCH.
  - RAM contents are not reset.
  - Reset mid-access aborts it: no valid pulse. A write already committed stays committed.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Grants are combinational from the req inputs, only in IDLE.
  - Single requestor: it is granted.
  - Both requesting: the requestor that did not win the last conflict is granted. Round-robin applies on conflict only; after reset data wins the first conflict.
  - At the grant edge, address, we, mask and wdata are latched and the owner is recorded. A write is committed to the RAM at that same edge.
  - Grant with LATENCY == 1 goes to RESP; otherwise to WAIT with counter = LATENCY-1.
- WAIT: busy=1; counter decrements each cycle; go to RESP when counter reaches 1.
- RESP:
  - The owner's valid is high for exactly one cycle.
  - For a read, rdata shows the word at the latched address. For a write, valid is an ack and rdata is unchanged.
  - rdata holds its value until the next read response on that port.
  - Next state is IDLE. No grant in RESP.
- Timing:
  - Grant in cycle T gives valid in cycle T+LATENCY.
  - The earliest next grant is cycle T+LATENCY+1, so peak throughput is one access per LATENCY+1 cycles.
- Requestor rules:
  - Hold req and address/data stable until gnt.
  - May drop req, or change inputs, the cycle after gnt.
  - A req held high through RESP is re-arbitrated in IDLE.
- Out of range (addr >= DEPTH):
  - Reads return 0.
  - Writes are dropped, but a write ack is still pulsed.
- Writes: only bytes with mask=1 change. A mask of all zeros is a legal no-op write that still acks.
- Read-after-write: a data write followed by a fetch of the same address returns the new data, because the write commits before any later grant.
- Simultaneous reads of the same address by both ports are serialised by the arbiter, never merged.

Decomposition:
- Shared package mem_pkg holds:
  - state enum {IDLE, WAIT, RESP};
  - owner enum {OWN_FETCH, OWN_DATA};
  - constant MAX_LATENCY=4.
- Sub-module mem_array: synchronous single-port RAM, DEPTH x DATA_W, per-byte write enables, registered read. The arbiter/FSM lives in unified_mem_arb.

Test Plan:
- Reset then single fetch, LATENCY=1: preload word 5=0xDEADBEEF, if_req with if_addr=5 at T -> if_gnt at T, if_valid at T+1 with if_rdata=0xDEADBEEF, busy=0 after.
- Byte-masked write then read, LATENCY=3:
  - preload word 2=0x11223344;
  - write d_wdata=0xAABBCCDD, d_mask=4'b0101 -> d_valid at T+3 (ack);
  - then read -> d_rdata=0x11BB33DD.
- Contention fairness: both req held continuously, LATENCY=1 -> grants alternate DATA, FETCH, DATA, FETCH, each grant 2 cycles apart.
- Write-then-fetch ordering: d write 0x00000013 to addr 7 and if read addr 7 asserted together -> data granted first, fetch returns 0x00000013.
- Out of range with DEPTH=128: read addr 200 -> d_valid with d_rdata=0; write addr 200 -> ack only, words 0..127 unchanged.
- Reset mid-access, LATENCY=4: drive rst low at T+2 -> no valid pulse, FSM IDLE, outputs 0; the next request completes normally.
